set_mode_ctrl: RTL and testbench
================================

# set_mode_ctrl

Button-sequencing controller for the alarm clock. It turns two raw front-panel buttons (Mode, Adv) into the level and advance controls the clock datapath consumes: Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Dateadv and Monthadv. It sits between the panel and the clock datapath top level and runs on the same 1/sec pulse clock. It owns the set-mode state machine, Adv auto-repeat and idle timeout.

## Interface
Parameters:
- HOLD_DLY, default 4: cycles from the Adv press edge to the first auto-repeat pulse (≥2).
- REP_PER, default 2: cycles between auto-repeat pulses (≥1).
- TMO, default 30: consecutive idle cycles in any set state before the block returns to RUN (≥2).

Ports:
- clk, input, 1: the only clock (the 1/sec Pulse).
- rst, input, 1: synchronous, active-high reset.
- mode_btn, input, 1: raw Mode button level, already synchronous to clk.
- adv_btn, input, 1: raw Adv button level, already synchronous to clk.
- Timeset, output, 1: high in states SET_MIN..SET_MONTH.
- Alarmset, output, 1: high in states ALM_MIN and ALM_HRS.
- Minadv, output, 1: one-cycle advance pulse in SET_MIN or ALM_MIN.
- Hrsadv, output, 1: one-cycle advance pulse in SET_HRS or ALM_HRS.
- Dayadv, output, 1: one-cycle advance pulse in SET_DAY.
- Dateadv, output, 1: one-cycle advance pulse in SET_DATE.
- Monthadv, output, 1: one-cycle advance pulse in SET_MONTH.
- mode_state, output, 3: current state code, used for display blink.

## Operation
- State codes: RUN=0, SET_MIN=1, SET_HRS=2, SET_DAY=3, SET_DATE=4, SET_MONTH=5, ALM_MIN=6, ALM_HRS=7.
- Mode edge = mode_btn high while its registered previous value is low. Each Mode edge advances the state by one, 0→1→…→7→0.
- Adv edge = adv_btn high while its registered previous value is low.
  - An Adv edge in a set state produces one advance pulse on the output selected by that state.
  - An Adv edge in RUN is ignored.
- Auto-repeat: while adv_btn stays high after an accepted edge, with no state change:
  - further pulses occur at edge+HOLD_DLY, then every REP_PER cycles after that.
  - The hold counter clears when adv_btn drops.
- Mode edge and Adv edge in the same cycle: Mode wins, the Adv edge is discarded, and the repeat is cancelled.
- A held Adv never repeats into a new state; a fresh press is required after any state change.
- Idle timeout:
  - The idle counter clears on any Mode or Adv edge and while adv_btn is high.
  - Otherwise it increments in set states and holds at 0 in RUN.
  - On the TMO-th consecutive idle cycle the state goes to RUN.
- At most one advance output is high in any cycle. Timeset and Alarmset are never both high.
- Counter widths are $clog2 of their parameter plus 1. Counters saturate and never wrap.

## Timing
- All outputs are registered, with one-cycle latency. An input sampled at posedge k produces its state or pulse change visible after posedge k.
- Each advance pulse is exactly one clk cycle wide, aligned with a level Timeset/Alarmset that is already stable.
- Leaving a set state: Timeset/Alarmset deassert in the same cycle the state changes. No advance pulse is issued in that cycle.
- Reset (synchronous, takes priority over everything):
  - state = RUN; all outputs = 0; hold and idle counters = 0.
  - The previous-value registers of both buttons load 1, so a button held through reset is not seen as an edge until it is released and pressed again.
- Reset asserted mid-repeat or mid-set aborts immediately. No pulse is issued in the reset cycle or the cycle after it.

## Configuration
- Macro SET_MODE_CTRL_AUTO_REPEAT_EN.
- Defined: auto-repeat behaves as described in Operation.
- Undefined: exactly one advance pulse per Adv press. The HOLD_DLY and REP_PER logic is removed, and the parameters remain but are ignored.
- Idle timeout and the state machine are identical in both builds.

## Test plan
- Reset, then 8 Mode presses 3 cycles apart → mode_state steps 1,2,…,7,0.
  - Timeset is high for states 1–5, Alarmset for states 6–7, neither in RUN.
- SET_HRS, single 1-cycle Adv press → exactly one Hrsadv pulse, one cycle after the press. No other advance output toggles.
- Auto-repeat (HOLD_DLY=4, REP_PER=2), ALM_MIN, Adv held 10 cycles from edge cycle 0 → Minadv pulses for press cycles 0, 4, 6, 8 (4 pulses).
  - With the macro undefined → a single pulse.
- Timeout (TMO=30), enter SET_DAY then idle → state stays 3 for 29 cycles and reads 0 after the 30th.
  - An Adv press at idle cycle 20 restarts the count.
- Mode and Adv edge in the same cycle in SET_MIN → state becomes SET_HRS, no Minadv and no Hrsadv. Keep Adv held → no repeat pulses.
- rst asserted during an Adv repeat in SET_MONTH with Adv still held → outputs 0, state RUN. No pulse after deassert until Adv is released and re-pressed (after Mode into a set state).

Source files
------------

// File: rtl/set_mode_ctrl.sv
// Set-mode controller: turns Mode/Adv buttons into set-level and advance-pulse controls.
// Optional macro SET_MODE_CTRL_AUTO_REPEAT_EN enables Adv auto-repeat while held.
module set_mode_ctrl #(
  parameter int HOLD_DLY = 4,
  parameter int REP_PER  = 2,
  parameter int TMO      = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       adv_btn,
  output logic       Timeset,
  output logic       Alarmset,
  output logic       Minadv,
  output logic       Hrsadv,
  output logic       Dayadv,
  output logic       Dateadv,
  output logic       Monthadv,
  output logic [2:0] mode_state
);

  localparam int IW = $clog2(TMO) + 1;
  localparam bit CFG_OK = (HOLD_DLY >= 2) && (REP_PER >= 1) && (TMO >= 2);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_MIN   = 3'd1,
    SET_HRS   = 3'd2,
    SET_DAY   = 3'd3,
    SET_DATE  = 3'd4,
    SET_MONTH = 3'd5,
    ALM_MIN   = 3'd6,
    ALM_HRS   = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic            mode_prev_q, adv_prev_q;
  logic [IW-1:0]   idle_q, idle_d;
  logic            timeset_q, timeset_d;
  logic            alarmset_q, alarmset_d;
  logic [4:0]      advp_q, advp_d;   // {month, date, day, hrs, min}

  logic            mode_edge_s, adv_edge_s, set_state_s, state_chg_s, fire_s;

`ifdef SET_MODE_CTRL_AUTO_REPEAT_EN
  localparam int HW = $clog2(HOLD_DLY) + 1;
  localparam int RW = $clog2(REP_PER) + 1;
  logic [HW-1:0]   hold_q, hold_d;
  logic [RW-1:0]   rep_q, rep_d;
`endif

  always_comb begin
    mode_edge_s = mode_btn & ~mode_prev_q;
    adv_edge_s  = adv_btn & ~adv_prev_q;
    set_state_s = (state_q != RUN);
    state_d     = state_q;
    idle_d      = idle_q;

    if (mode_edge_s || adv_edge_s || adv_btn) begin
      idle_d = '0;
    end else if (set_state_s) begin
      if (idle_q >= IW'(TMO - 1)) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end

    if (mode_edge_s) begin
      state_d = state_t'(state_q + 3'd1);
    end else if (set_state_s && !adv_btn && (idle_q >= IW'(TMO - 1))) begin
      state_d = RUN;
    end else begin
      state_d = state_q;
    end

    state_chg_s = (state_d != state_q);
    fire_s      = 1'b0;

`ifdef SET_MODE_CTRL_AUTO_REPEAT_EN
    hold_d = hold_q;
    rep_d  = rep_q;
    // hold_q != 0 marks an accepted press still held in the state it was taken in
    if (!adv_btn || state_chg_s) begin
      hold_d = '0;
      rep_d  = '0;
    end else if (adv_edge_s && set_state_s) begin
      hold_d = HW'(1);
      rep_d  = '0;
      fire_s = 1'b1;
    end else if (hold_q != '0) begin
      if (hold_q < HW'(HOLD_DLY)) begin
        hold_d = hold_q + 1'b1;
      end else if ((rep_q == '0) || (rep_q >= RW'(REP_PER))) begin
        fire_s = 1'b1;
        rep_d  = RW'(1);
      end else begin
        rep_d = rep_q + 1'b1;
      end
    end else begin
      hold_d = '0;
      rep_d  = '0;
    end
`else
    if (adv_edge_s && set_state_s && !state_chg_s) begin
      fire_s = 1'b1;
    end else begin
      fire_s = 1'b0;
    end
`endif

    timeset_d  = (state_d >= SET_MIN) && (state_d <= SET_MONTH);
    alarmset_d = (state_d >= ALM_MIN);

    advp_d = 5'b00000;
    if (fire_s && CFG_OK) begin
      case (state_q)
        SET_MIN, ALM_MIN: advp_d = 5'b00001;
        SET_HRS, ALM_HRS: advp_d = 5'b00010;
        SET_DAY:          advp_d = 5'b00100;
        SET_DATE:         advp_d = 5'b01000;
        SET_MONTH:        advp_d = 5'b10000;
        default:          advp_d = 5'b00000;
      endcase
    end else begin
      advp_d = 5'b00000;
    end
  end

  // Buttons held through reset must be released before they count as edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b1;
      adv_prev_q  <= 1'b1;
      idle_q      <= '0;
      timeset_q   <= 1'b0;
      alarmset_q  <= 1'b0;
      advp_q      <= 5'b00000;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_btn;
      adv_prev_q  <= adv_btn;
      idle_q      <= idle_d;
      timeset_q   <= timeset_d;
      alarmset_q  <= alarmset_d;
      advp_q      <= advp_d;
    end
  end

`ifdef SET_MODE_CTRL_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= '0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`endif

  assign mode_state = state_q;
  assign Timeset    = timeset_q;
  assign Alarmset   = alarmset_q;
  assign Minadv     = advp_q[0];
  assign Hrsadv     = advp_q[1];
  assign Dayadv     = advp_q[2];
  assign Dateadv    = advp_q[3];
  assign Monthadv   = advp_q[4];

endmodule

// File: tb/tb_set_mode_ctrl.sv
// Directed bench for set_mode_ctrl; expected values are hand-computed for the default parameters.
module tb_set_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst, mode_btn, adv_btn;
  logic       Timeset, Alarmset, Minadv, Hrsadv, Dayadv, Dateadv, Monthadv;
  logic [2:0] mode_state;

  int tests = 0;
  int fails = 0;
  int cnt_min, cnt_hrs, cnt_day, cnt_date, cnt_month;
  int excl_viol = 0;
  logic [9:0] mask;
  logic [9:0] exp_mask;
  int exp_rep_cnt, exp_month_cnt;

  set_mode_ctrl #(.HOLD_DLY(4), .REP_PER(2), .TMO(30)) dut (
    .clk(clk), .rst(rst), .mode_btn(mode_btn), .adv_btn(adv_btn),
    .Timeset(Timeset), .Alarmset(Alarmset), .Minadv(Minadv), .Hrsadv(Hrsadv),
    .Dayadv(Dayadv), .Dateadv(Dateadv), .Monthadv(Monthadv), .mode_state(mode_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_min = 0; cnt_hrs = 0; cnt_day = 0; cnt_date = 0; cnt_month = 0;
  endtask

  // Advance to the next falling edge(s), tallying pulses and exclusivity violations.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      cnt_min   += int'(Minadv);
      cnt_hrs   += int'(Hrsadv);
      cnt_day   += int'(Dayadv);
      cnt_date  += int'(Dateadv);
      cnt_month += int'(Monthadv);
      if ((int'(Minadv) + int'(Hrsadv) + int'(Dayadv) + int'(Dateadv) + int'(Monthadv)) > 1
          || (Timeset && Alarmset))
        excl_viol++;
    end
  endtask

  task automatic mode_press();
    mode_btn = 1'b1;
    tick(1);
    mode_btn = 1'b0;
    tick(2);
  endtask

  initial begin
`ifdef SET_MODE_CTRL_AUTO_REPEAT_EN
    exp_mask = 10'h151; exp_rep_cnt = 4; exp_month_cnt = 2;
`else
    exp_mask = 10'h001; exp_rep_cnt = 1; exp_month_cnt = 1;
`endif
    clear_counts();
    rst = 1'b1; mode_btn = 1'b0; adv_btn = 1'b0;
    tick(3);
    rst = 1'b0;
    check("rst_state", int'(mode_state), 0);
    check("rst_timeset", int'(Timeset), 0);
    check("rst_alarmset", int'(Alarmset), 0);
    tick(1);
    check("rst_adv_outs", int'({Minadv, Hrsadv, Dayadv, Dateadv, Monthadv}), 0);

    // Mode walk through all eight states
    for (int i = 1; i <= 8; i++) begin
      mode_btn = 1'b1;
      tick(1);
      check($sformatf("mode_step%0d", i), int'(mode_state), i % 8);
      check($sformatf("timeset%0d", i), int'(Timeset), (i >= 1 && i <= 5) ? 1 : 0);
      check($sformatf("alarmset%0d", i), int'(Alarmset), (i >= 6 && i <= 7) ? 1 : 0);
      mode_btn = 1'b0;
      tick(2);
    end
    check("walk_no_pulses", cnt_min + cnt_hrs + cnt_day + cnt_date + cnt_month, 0);

    // Single press in SET_HRS
    mode_press(); mode_press();
    check("in_set_hrs", int'(mode_state), 2);
    clear_counts();
    adv_btn = 1'b1;
    tick(1);
    check("hrsadv_pulse", int'(Hrsadv), 1);
    check("minadv_quiet", int'(Minadv), 0);
    adv_btn = 1'b0;
    tick(1);
    check("hrsadv_one_wide", int'(Hrsadv), 0);
    tick(4);
    check("hrs_count", cnt_hrs, 1);
    check("other_counts", cnt_min + cnt_day + cnt_date + cnt_month, 0);

    // Held Adv in ALM_MIN
    repeat (4) mode_press();
    check("in_alm_min", int'(mode_state), 6);
    clear_counts();
    mask = '0;
    adv_btn = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick(1);
      if (Minadv) mask[n] = 1'b1;
    end
    adv_btn = 1'b0;
    tick(3);
    check("repeat_mask", int'(mask), int'(exp_mask));
    check("repeat_count", cnt_min, exp_rep_cnt);

    // Idle timeout in SET_DAY with a restart at idle cycle 20
    repeat (5) mode_press();
    tick(17);
    check("tmo_pre_press", int'(mode_state), 3);
    clear_counts();
    adv_btn = 1'b1;
    tick(1);
    check("dayadv_pulse", int'(Dayadv), 1);
    adv_btn = 1'b0;
    tick(29);
    check("tmo_still_set", int'(mode_state), 3);
    check("tmo_timeset_hi", int'(Timeset), 1);
    tick(1);
    check("tmo_to_run", int'(mode_state), 0);
    check("tmo_timeset_lo", int'(Timeset), 0);
    check("day_count", cnt_day, 1);

    // Simultaneous Mode and Adv edges in SET_MIN
    mode_press();
    check("in_set_min", int'(mode_state), 1);
    clear_counts();
    mode_btn = 1'b1; adv_btn = 1'b1;
    tick(1);
    check("both_state", int'(mode_state), 2);
    check("both_minadv", int'(Minadv), 0);
    check("both_hrsadv", int'(Hrsadv), 0);
    mode_btn = 1'b0;
    tick(10);
    check("both_no_repeat", cnt_min + cnt_hrs, 0);
    adv_btn = 1'b0;
    tick(2);

    // Reset during a repeat in SET_MONTH
    repeat (3) mode_press();
    check("in_set_month", int'(mode_state), 5);
    clear_counts();
    adv_btn = 1'b1;
    tick(5);
    check("month_count", cnt_month, exp_month_cnt);
    rst = 1'b1;
    tick(1);
    check("midrst_state", int'(mode_state), 0);
    check("midrst_timeset", int'(Timeset), 0);
    check("midrst_monthadv", int'(Monthadv), 0);
    rst = 1'b0;
    clear_counts();
    tick(3);
    mode_press();
    tick(3);
    check("held_thru_rst_state", int'(mode_state), 1);
    check("held_thru_rst_nopulse", cnt_min + cnt_hrs + cnt_day + cnt_date + cnt_month, 0);
    adv_btn = 1'b0;
    tick(1);
    adv_btn = 1'b1;
    tick(1);
    check("repress_minadv", int'(Minadv), 1);
    adv_btn = 1'b0;
    tick(2);
    check("exclusivity", excl_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
